// File: rtl/fsm_step_arbiter_pkg.sv
// Shared types and default widths for the single-step FSM arbiter.
package fsm_step_arbiter_pkg;

    localparam int DEF_X_W   = 16;
    localparam int DEF_Y_W   = 17;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CORE_RST = 2'd1,
        ISSUE    = 2'd2,
        RESP     = 2'd3
    } step_state_t;

endpackage

// File: rtl/fsm_step_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the requester that did not win last time has priority.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    // Pick the winner among the valid requesters
    always_comb begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
        if (req == 2'b11) begin
            gnt_id = ~last_grant;
            gnt    = last_grant ? 2'b01 : 2'b10;
        end else if (req[1]) begin
            gnt_id = 1'b1;
            gnt    = 2'b10;
        end else if (req[0]) begin
            gnt_id = 1'b0;
            gnt    = 2'b01;
        end
    end

endmodule

// File: rtl/fsm_step_arbiter.sv
// Grants exclusive single-step access to a shared FSM core: optional core reset,
// one enabled clock with the requester's vector, then a held response.
module fsm_step_arbiter
    import fsm_step_arbiter_pkg::*;
#(
    parameter int X_W        = DEF_X_W,
    parameter int Y_W        = DEF_Y_W,
    parameter int RST_CYCLES = 2,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [X_W-1:0]   req0_x,
    input  logic             req0_init,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [X_W-1:0]   req1_x,
    input  logic             req1_init,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [Y_W-1:0]   resp_y,
    output logic [CNT_W-1:0] resp_cnt,
    output logic [X_W-1:0]   core_x,
    output logic             core_en,
    output logic             core_rst,
    input  logic [Y_W-1:0]   core_y
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    step_state_t      state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [X_W-1:0]   lat_x_q, lat_x_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_id_q, resp_id_d;
    logic [Y_W-1:0]   resp_y_q, resp_y_d;
    logic [CNT_W-1:0] resp_cnt_q, resp_cnt_d;
    logic [X_W-1:0]   core_x_q, core_x_d;
    logic             core_en_q, core_en_d;
    logic             core_rst_q, core_rst_d;

    logic [1:0]       gnt;
    logic             gnt_id;
    logic             take;
    logic [X_W-1:0]   sel_x;
    logic             sel_init;
    logic [CNT_W-1:0] cnt_inc;

    // Step counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    rr_arb2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .gnt        (gnt),
        .gnt_id     (gnt_id)
    );

    assign req0_ready = (state_q == IDLE) && gnt[0];
    assign req1_ready = (state_q == IDLE) && gnt[1];
    assign take       = (state_q == IDLE) && (gnt != 2'b00);
    assign sel_x      = gnt_id ? req1_x : req0_x;
    assign sel_init   = gnt_id ? req1_init : req0_init;
    assign cnt_inc    = sat_inc(owner_q ? cnt1_q : cnt0_q);

    // Next-state and next-output computation for the step sequence
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        lat_x_d      = lat_x_q;
        rst_cnt_d    = rst_cnt_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_y_d     = resp_y_q;
        resp_cnt_d   = resp_cnt_q;
        core_x_d     = core_x_q;
        core_en_d    = 1'b0;
        core_rst_d   = core_rst_q;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    last_grant_d = gnt_id;
                    owner_d      = gnt_id;
                    lat_x_d      = sel_x;
                    if (sel_init) begin
                        state_d    = CORE_RST;
                        core_rst_d = 1'b1;
                        rst_cnt_d  = RC_W'(RST_CYCLES - 1);
                        if (gnt_id) cnt1_d = '0;
                        else        cnt0_d = '0;
                    end else begin
                        state_d   = ISSUE;
                        core_en_d = 1'b1;
                        core_x_d  = sel_x;
                    end
                end
            end
            CORE_RST: begin
                if (rst_cnt_q == '0) begin
                    state_d    = ISSUE;
                    core_rst_d = 1'b0;
                    core_en_d  = 1'b1;
                    core_x_d   = lat_x_q;
                end else begin
                    rst_cnt_d = rst_cnt_q - 1'b1;
                end
            end
            ISSUE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_y_d     = core_y;
                resp_cnt_d   = cnt_inc;
                resp_id_d    = owner_q;
                if (owner_q) cnt1_d = cnt_inc;
                else         cnt0_d = cnt_inc;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs; rst returns everything to idle-zero
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            lat_x_q      <= '0;
            rst_cnt_q    <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_y_q     <= '0;
            resp_cnt_q   <= '0;
            core_x_q     <= '0;
            core_en_q    <= 1'b0;
            core_rst_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            lat_x_q      <= lat_x_d;
            rst_cnt_q    <= rst_cnt_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_y_q     <= resp_y_d;
            resp_cnt_q   <= resp_cnt_d;
            core_x_q     <= core_x_d;
            core_en_q    <= core_en_d;
            core_rst_q   <= core_rst_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_y     = resp_y_q;
    assign resp_cnt   = resp_cnt_q;
    assign core_x     = core_x_q;
    assign core_en    = core_en_q;
    assign core_rst   = core_rst_q;

endmodule

// File: tb/tb_fsm_step_arbiter.sv
// Scoreboard bench for fsm_step_arbiter with a stub FSM core.
module tb_fsm_step_arbiter;

    localparam int X_W        = 16;
    localparam int Y_W        = 17;
    localparam int RST_CYCLES = 2;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [X_W-1:0]   req0_x = '0, req1_x = '0;
    logic             req0_init = 1'b0, req1_init = 1'b0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic             resp_id;
    logic [Y_W-1:0]   resp_y;
    logic [CNT_W-1:0] resp_cnt;
    logic [X_W-1:0]   core_x;
    logic             core_en, core_rst;
    logic [Y_W-1:0]   core_y;

    fsm_step_arbiter #(.X_W(X_W), .Y_W(Y_W), .RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_init(req0_init),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_init(req1_init),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_y(resp_y), .resp_cnt(resp_cnt),
        .core_x(core_x), .core_en(core_en), .core_rst(core_rst), .core_y(core_y)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stub core and its abstract description ----------------
    function automatic logic [Y_W-1:0] fy(input logic [X_W-1:0] x, input logic [7:0] s);
        return {1'b0, x} ^ {s, 9'b0} ^ 17'h0A5A5;
    endfunction
    function automatic logic [7:0] fg(input logic [7:0] s, input logic [X_W-1:0] x);
        return s + x[7:0] + 8'd1;
    endfunction

    logic [7:0] core_s = '0;
    bit         stub_const = 1'b0;
    always @(posedge clk) begin
        if (rst || core_rst) core_s <= '0;
        else if (core_en)    core_s <= fg(core_s, core_x);
    end
    assign core_y = stub_const ? 17'h00141 : fy(core_x, core_s);

    // ---------------- scoreboard state ----------------
    typedef struct {
        bit             id;
        logic [Y_W-1:0] y;
        int             cnt;
        int             rcyc;
    } exp_t;
    exp_t exp_q[$];

    int n_chk = 0, n_pass = 0;
    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    endtask

    // model state (reference model process)
    bit             m_last = 1'b1;
    int             mcnt[2] = '{0, 0};
    logic [7:0]     mcs = '0;
    logic [X_W-1:0] m_x = '0, m_cx = '0;
    int             issue_cyc = -10, crst_lo = -10, crst_hi = -20;
    int             flush_n = 0, rst_cyc = 0;
    int             rd_eff;
    bit             idle, e_r0, e_r1, a_id, a_init;
    logic [X_W-1:0] a_x;
    exp_t           e_new;

    // monitor state
    int   mon_rd = 0, mon_done_cyc = -1;
    bit   seen = 1'b0;
    int   zero_chk_cyc = -1;
    exp_t e_cur;

    // Reference model: predicts grants, core strobes and responses from the rules
    always @(negedge clk) begin
        if (rst) begin
            m_last = 1'b1; mcnt[0] = 0; mcnt[1] = 0; mcs = '0; m_cx = '0;
            issue_cyc = -10; crst_lo = -10; crst_hi = -20;
            flush_n = exp_q.size(); rst_cyc = cyc;
        end else begin
            rd_eff = (mon_rd > flush_n) ? mon_rd : flush_n;
            idle = (rd_eff >= exp_q.size()) && (cyc > mon_done_cyc) && (cyc > rst_cyc);
            e_r0 = 1'b0; e_r1 = 1'b0;
            if (idle) begin
                if (req0_valid && req1_valid) begin
                    if (m_last) e_r0 = 1'b1; else e_r1 = 1'b1;
                end else if (req0_valid) e_r0 = 1'b1;
                else if (req1_valid) e_r1 = 1'b1;
            end
            chk(req0_ready === e_r0, "req0_ready", req0_ready, e_r0);
            chk(req1_ready === e_r1, "req1_ready", req1_ready, e_r1);
            if (cyc == issue_cyc) m_cx = m_x;
            chk(core_en === (cyc == issue_cyc), "core_en", core_en, cyc == issue_cyc);
            chk(core_rst === (cyc >= crst_lo && cyc <= crst_hi), "core_rst", core_rst,
                cyc >= crst_lo && cyc <= crst_hi);
            chk(core_x === m_cx, "core_x", core_x, m_cx);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                a_id   = req1_valid && req1_ready;
                a_x    = a_id ? req1_x : req0_x;
                a_init = a_id ? req1_init : req0_init;
                m_last = a_id;
                m_x    = a_x;
                if (a_init) begin mcnt[a_id] = 0; mcs = '0; end
                issue_cyc = cyc + 1 + (a_init ? RST_CYCLES : 0);
                crst_lo   = cyc + 1;
                crst_hi   = a_init ? cyc + RST_CYCLES : cyc;
                e_new.y   = stub_const ? 17'h00141 : fy(a_x, mcs);
                mcs       = fg(mcs, a_x);
                if (mcnt[a_id] < CNT_MAX) mcnt[a_id]++;
                e_new.id   = a_id;
                e_new.cnt  = mcnt[a_id];
                e_new.rcyc = issue_cyc + 1;
                exp_q.push_back(e_new);
            end
        end
    end

    // Monitor: compares each presented response against the scoreboard head
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else begin
            if (mon_rd < flush_n) mon_rd = flush_n;
            if (cyc == zero_chk_cyc) begin
                chk(resp_valid === 1'b0, "rst_resp_valid", resp_valid, 0);
                chk(resp_id === 1'b0, "rst_resp_id", resp_id, 0);
                chk(resp_y === '0, "rst_resp_y", resp_y, 0);
                chk(resp_cnt === '0, "rst_resp_cnt", resp_cnt, 0);
                chk(core_x === '0, "rst_core_x", core_x, 0);
                chk(core_en === 1'b0, "rst_core_en", core_en, 0);
                chk(core_rst === 1'b0, "rst_core_rst", core_rst, 0);
            end
            if (resp_valid) begin
                if (mon_rd >= exp_q.size()) begin
                    chk(1'b0, "resp_unexpected", resp_valid, 0);
                end else begin
                    e_cur = exp_q[mon_rd];
                    if (!seen) begin
                        chk(cyc == e_cur.rcyc, "resp_latency", cyc, e_cur.rcyc);
                        seen = 1'b1;
                    end
                    chk(resp_id === e_cur.id, "resp_id", resp_id, e_cur.id);
                    chk(resp_y === e_cur.y, "resp_y", resp_y, e_cur.y);
                    chk(int'(resp_cnt) == e_cur.cnt, "resp_cnt", resp_cnt, e_cur.cnt);
                    if (resp_ready) begin
                        mon_rd++;
                        mon_done_cyc = cyc;
                        seen = 1'b0;
                    end
                end
            end else if (mon_rd < exp_q.size() && cyc >= exp_q[mon_rd].rcyc) begin
                chk(1'b0, "resp_missing", 0, 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    bit             gen_en = 1'b0, fix_en = 1'b0, bp_mode = 1'b0;
    int             pv0 = 0, pv1 = 0, pinit = 0, pready = 100, pdrop = 0;
    logic [X_W-1:0] fix_x = '0;
    bit             pend0 = 1'b0, pend1 = 1'b0, h0 = 1'b0, h1 = 1'b0;
    logic [X_W-1:0] px0 = '0, px1 = '0;
    bit             pi0 = 1'b0, pi1 = 1'b0;
    int             bp_cnt = 0;

    task automatic apply();
        req0_valid = pend0; req0_x = px0; req0_init = pi0;
        req1_valid = pend1; req1_x = px1; req1_init = pi1;
    endtask

    task automatic drive_cycle();
        @(negedge clk);
        h0 = req0_valid && req0_ready;
        h1 = req1_valid && req1_ready;
        @(posedge clk);
        #1;
        if (h0) pend0 = 1'b0;
        if (h1) pend1 = 1'b0;
        if (gen_en) begin
            if (!pend0 && $urandom_range(99) < pv0) begin
                pend0 = 1'b1; px0 = fix_en ? fix_x : X_W'($urandom); pi0 = $urandom_range(99) < pinit;
            end else if (pend0 && $urandom_range(99) < pdrop) pend0 = 1'b0;
            if (!pend1 && $urandom_range(99) < pv1) begin
                pend1 = 1'b1; px1 = fix_en ? fix_x : X_W'($urandom); pi1 = $urandom_range(99) < pinit;
            end else if (pend1 && $urandom_range(99) < pdrop) pend1 = 1'b0;
        end
        apply();
        if (bp_mode) begin
            if (resp_valid) begin
                resp_ready = (bp_cnt >= 4);
                bp_cnt++;
            end else begin
                resp_ready = 1'b0;
                bp_cnt = 0;
            end
        end else begin
            resp_ready = $urandom_range(99) < pready;
        end
    endtask

    task automatic do_reset();
        gen_en = 1'b0; bp_mode = 1'b0; pend0 = 1'b0; pend1 = 1'b0; h0 = 1'b0; h1 = 1'b0;
        apply();
        resp_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        zero_chk_cyc = cyc;
    endtask

    task automatic run_steps(input int n, input int v0, input int v1, input int pi, input int pr);
        int got = 0;
        int guard = 0;
        pv0 = v0; pv1 = v1; pinit = pi; pready = pr; gen_en = 1'b1;
        while (got < n) begin
            drive_cycle();
            got += int'(h0) + int'(h1);
            guard++;
            if (guard > 3000) begin
                $display("FAIL timeout_accept: got %0d grants, expected %0d", got, n);
                $fatal(1);
            end
        end
        gen_en = 1'b0; pend0 = 1'b0; pend1 = 1'b0;
        apply();
        guard = 0;
        while (!((mon_rd >= exp_q.size()) && (cyc > mon_done_cyc + 1))) begin
            drive_cycle();
            guard++;
            if (guard > 500) begin
                $display("FAIL timeout_drain: got %0d responses, expected %0d", mon_rd, exp_q.size());
                $fatal(1);
            end
        end
    endtask

    task automatic reset_mid(input bit in_resp);
        int guard = 0;
        pv0 = 100; pv1 = 0; pinit = 0; pready = 0; gen_en = 1'b1; h0 = 1'b0;
        while (!h0) begin
            drive_cycle();
            guard++;
            if (guard > 20) begin
                $display("FAIL timeout_mid_accept: got no grant, expected one");
                $fatal(1);
            end
        end
        gen_en = 1'b0; pend0 = 1'b0;
        apply();
        if (in_resp) drive_cycle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        zero_chk_cyc = cyc;
        run_steps(2, 100, 100, 0, 100);
    endtask

    initial begin
        do_reset();
        // single step with a constant-output core
        stub_const = 1'b1; fix_en = 1'b1; fix_x = 16'h0054;
        run_steps(1, 100, 0, 0, 100);
        stub_const = 1'b0; fix_en = 1'b0;
        // contention with fresh counters
        do_reset();
        run_steps(4, 100, 100, 0, 100);
        // init after five plain req1 steps
        do_reset();
        run_steps(5, 0, 100, 0, 100);
        run_steps(1, 0, 100, 100, 100);
        // backpressure on the response
        do_reset();
        bp_mode = 1'b1;
        run_steps(2, 100, 100, 0, 0);
        bp_mode = 1'b0;
        // counter saturation
        do_reset();
        run_steps(17, 100, 0, 0, 100);
        // reset during ISSUE, then during RESP
        do_reset();
        run_steps(1, 100, 0, 0, 100);
        reset_mid(1'b0);
        run_steps(1, 100, 0, 0, 100);
        reset_mid(1'b1);
        // randomized traffic
        do_reset();
        pdrop = 10;
        run_steps(80, 60, 60, 25, 70);
        pdrop = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
